wind_input_conditioner: RTL
===========================

WIND_INPUT_CONDITIONER -- requirements
Module: wind_input_conditioner

Interface
REQ-001 Parameter: DEBOUNCE_CYCLES, 4, consecutive stable synchronized cycles required to accept a new switch code (>=1).
REQ-002 Parameter: TICK_DIV, 8, clock cycles per step strobe (>=2).
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 sw  input  2  raw asynchronous wind switches; 00 calm, 01 right-to-left, 10 left-to-right, 11 illegal.
REQ-006 run  input  1  step-strobe enable; low freezes divider.
REQ-007 bits  output  2  debounced legal wind code, registered; feeds the runway pattern FSM.
REQ-008 step  output  1  one-cycle advance strobe for the pattern FSM.
REQ-009 changed  output  1  one-cycle pulse when bits takes a new value.
REQ-010 illegal  output  1  level; high while the debounced code is 11.

Function
REQ-011 sw SHALL pass through a two-flop synchronizer before any other use.
REQ-012 Debouncer SHALL hold a candidate code and a stability count; when synchronized value differs from candidate, candidate <= synchronized value and count <= 0; otherwise count increments, saturating at DEBOUNCE_CYCLES-1.
REQ-013 Debounced code SHALL be accepted on the edge where count == DEBOUNCE_CYCLES-1 and candidate equals synchronized value; total latency from sw change to bits update SHALL be exactly DEBOUNCE_CYCLES+2 edges when sw is held constant.
REQ-014 A glitch shorter than DEBOUNCE_CYCLES synchronized cycles SHALL NOT change bits, changed, or illegal.
REQ-015 Accepted code 11 SHALL NOT be forwarded: bits holds its previous value, changed stays 0, illegal asserts the same edge bits would have updated.
REQ-016 illegal SHALL deassert on the edge a legal code is accepted.
REQ-017 Accepted legal code different from bits: bits updates and changed pulses high for exactly one cycle; legal code equal to bits: no pulse.
REQ-018 Divider counts 0..TICK_DIV-1 while run=1; step=1 for the single cycle count == TICK_DIV-1, then wraps to 0.
REQ-019 run=0: divider holds its value, step=0.
REQ-020 On a changed pulse the divider SHALL restart at 0, so the next step occurs TICK_DIV cycles later; if terminal count coincides with changed, step still asserts that cycle and divider restarts at 0.
REQ-021 step, changed SHALL never be high longer than one cycle per event.

Reset
REQ-022 On reset: bits=00, step=0, changed=0, illegal=0, synchronizer flops=00, candidate=00, stability count=0, divider=0.
REQ-023 Reset mid-debounce SHALL discard the pending candidate; reset dominates run and all events on the same edge.
REQ-024 First step after reset release SHALL occur TICK_DIV cycles after release with run=1.

Structure
REQ-025 Package wind_pkg SHALL hold wind_code_t (CALM=00, R2L=01, L2R=10, ILLEGAL=11) and default values of DEBOUNCE_CYCLES and TICK_DIV; the pattern FSM shares it.
REQ-026 Divider SHALL be a sub-module step_divider (ports clk, reset, run, restart, step); debouncer stays inline.

Verification (DEBOUNCE_CYCLES=4, TICK_DIV=8)
REQ-027 Reset, run=1, sw=00 held -> bits=00, step pulses at cycles 8, 16, 24 after release, changed never high.
REQ-028 sw 00->10 held -> bits=10 exactly 6 edges after change, changed one-cycle pulse, next step 8 cycles after pulse.
REQ-029 sw=01 for 2 cycles then back to 00 -> bits stays 00, no changed, no illegal.
REQ-030 bits=01, sw->11 held 10 cycles, then sw->10 -> bits stays 01 and illegal=1 during 11; then bits=10, illegal=0, changed pulse.
REQ-031 run=0 for 5 cycles mid-count at divider=3 -> step=0; resumes, step 4 cycles after run=1.
REQ-032 Reset asserted 2 cycles into a 00->01 debounce -> all outputs per REQ-022, bits never shows 01.

Source files
------------

// File: rtl/wind_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | wind_pkg : wind switch codes and conditioner defaults                |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package wind_pkg;

  typedef enum logic [1:0] {
    CALM    = 2'b00,
    R2L     = 2'b01,
    L2R     = 2'b10,
    ILLEGAL = 2'b11
  } wind_code_t;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 4;
  localparam int DEFAULT_TICK_DIV        = 8;

  function automatic logic is_legal(input wind_code_t code);
    return code != ILLEGAL;
  endfunction

endpackage
`default_nettype wire

// File: rtl/step_divider.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | step_divider : free-running step strobe, gated by run, restartable   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module step_divider #(
  parameter int TICK_DIV = wind_pkg::DEFAULT_TICK_DIV
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic restart,
  output logic step
);

  localparam int              CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0]   TERM = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign step = run && (cnt_q == TERM);

  // Restart wins over run so a new wind code always realigns the step phase.
  always_comb begin
    cnt_d = cnt_q;
    if (restart) begin
      cnt_d = '0;
    end else if (run) begin
      cnt_d = (cnt_q == TERM) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/wind_input_conditioner.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | wind_input_conditioner : sync + debounce wind switches, step strobe  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module wind_input_conditioner
  import wind_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int TICK_DIV        = DEFAULT_TICK_DIV
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] sw,
  input  logic       run,
  output logic [1:0] bits,
  output logic       step,
  output logic       changed,
  output logic       illegal
);

  localparam int            SW       = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [SW-1:0] STAB_MAX = SW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync1_q;
  logic [1:0]    sync2_q;
  wind_code_t    cand_q;
  wind_code_t    cand_d;
  logic [SW-1:0] stab_q;
  logic [SW-1:0] stab_d;
  wind_code_t    bits_q;
  wind_code_t    bits_d;
  logic          changed_q;
  logic          changed_d;
  logic          illegal_q;
  logic          illegal_d;
  logic          accept;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 2'b00;
      sync2_q <= 2'b00;
    end else begin
      sync1_q <= sw;
      sync2_q <= sync1_q;
    end
  end

  // Acceptance is judged on the updated count so that the load edge counts
  // as the first stable cycle; sw-to-bits latency is DEBOUNCE_CYCLES+2.
  always_comb begin
    cand_d = cand_q;
    stab_d = stab_q;
    if (sync2_q != cand_q) begin
      cand_d = wind_code_t'(sync2_q);
      stab_d = '0;
    end else if (stab_q != STAB_MAX) begin
      stab_d = stab_q + 1'b1;
    end
    accept = (stab_d == STAB_MAX);
  end

  always_comb begin
    bits_d    = bits_q;
    changed_d = 1'b0;
    illegal_d = illegal_q;
    if (accept) begin
      if (!is_legal(cand_d)) begin
        illegal_d = 1'b1;
      end else begin
        illegal_d = 1'b0;
        if (cand_d != bits_q) begin
          bits_d    = cand_d;
          changed_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cand_q    <= CALM;
      stab_q    <= '0;
      bits_q    <= CALM;
      changed_q <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      cand_q    <= cand_d;
      stab_q    <= stab_d;
      bits_q    <= bits_d;
      changed_q <= changed_d;
      illegal_q <= illegal_d;
    end
  end

  assign bits    = bits_q;
  assign changed = changed_q;
  assign illegal = illegal_q;

  // Restart on the edge changed rises, so the divider phase lines up with it.
  step_divider #(
    .TICK_DIV (TICK_DIV)
  ) u_step_divider (
    .clk     (clk),
    .reset   (reset),
    .run     (run),
    .restart (changed_d),
    .step    (step)
  );

endmodule
`default_nettype wire
